// File: rtl/pr_ctrl_pkg.sv
// Shared types and default timing constants for the partial-reconfiguration sequencer.
package pr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_RM,
        ST_SETTLE,
        ST_IDLE,
        ST_DRAIN,
        ST_GRANT,
        ST_ERROR
    } state_t;

    localparam int DEF_DATA_W         = 16;
    localparam int DEF_DRAIN_CYCLES   = 4;
    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_SETTLE_CYCLES  = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    // One counter serves every timed state, so size it for the longest dwell.
    function automatic int cnt_width(input int timeout_c, input int rst_c,
                                     input int settle_c, input int drain_c);
        int m;
        m = timeout_c;
        if (rst_c > m)    m = rst_c;
        if (settle_c > m) m = settle_c;
        if (drain_c > m)  m = drain_c;
        return $clog2(m + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT_CYCLES, DEF_RST_CYCLES,
                                         DEF_SETTLE_CYCLES, DEF_DRAIN_CYCLES);

endpackage

// File: rtl/pr_cycle_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module pr_cycle_timer #(
    parameter int             CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/pr_decouple_seq.sv
// Decouple/grant/reset/settle sequencer around the reconfigurable module, with
// a stuck-reconfiguration timeout and a count of successful reconfigurations.
module pr_decouple_seq
    import pr_ctrl_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rm_data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              pr_req,
    output logic              pr_ack,
    input  logic              pr_done,
    input  logic              err_clr,
    output logic              decouple,
    output logic              rm_reset,
    output logic              busy,
    output logic              error,
    output logic [7:0]        reconfig_count
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, RST_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES);

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_expired;
    logic               r_decouple, r_rm_reset, r_busy, r_error, r_pr_ack;
    logic               r_done_seen;
    logic [DATA_W-1:0]  r_data;
    logic [7:0]         r_count;

    // Dwell of N cycles: load N-1 on entry, leave on the cycle the count reads zero.
    pr_cycle_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(RST_CYCLES - 1))
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RESET_RM: if (w_expired) w_next = ST_SETTLE;
            ST_SETTLE:   if (w_expired) w_next = ST_IDLE;
            ST_IDLE:     if (pr_req)    w_next = ST_DRAIN;
            ST_DRAIN:    if (w_expired) w_next = ST_GRANT;
            ST_GRANT: begin
                if (pr_done)        w_next = ST_RESET_RM;
                else if (w_expired) w_next = ST_ERROR;
            end
            ST_ERROR:    if (err_clr)   w_next = ST_RESET_RM;
            default:     w_next = ST_RESET_RM;
        endcase
    end

    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = '0;
        unique case (w_next)
            ST_RESET_RM: w_load_val = CNT_W'(RST_CYCLES - 1);
            ST_SETTLE:   w_load_val = CNT_W'(SETTLE_CYCLES - 1);
            ST_DRAIN:    w_load_val = CNT_W'(DRAIN_CYCLES - 1);
            ST_GRANT:    w_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
            default:     w_load_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RESET_RM;
            r_decouple <= 1'b1;
            r_rm_reset <= 1'b1;
            r_busy     <= 1'b1;
            r_pr_ack   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_decouple <= (w_next != ST_IDLE);
            r_busy     <= (w_next != ST_IDLE);
            r_pr_ack   <= (w_next == ST_GRANT);
            r_rm_reset <= (w_next == ST_RESET_RM) || (w_next == ST_ERROR);
            r_error    <= (w_next == ST_ERROR);
        end
    end

    // Only a pr_done-terminated grant arms the counter; error recovery never does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_seen <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            if (r_state == ST_GRANT && pr_done) begin
                r_done_seen <= 1'b1;
            end else if (r_state == ST_SETTLE && w_next == ST_IDLE) begin
                r_done_seen <= 1'b0;
                if (r_done_seen) r_count <= r_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (!r_decouple) begin
            r_data <= rm_data_in;
        end
    end

    assign data_out       = r_data;
    assign pr_ack         = r_pr_ack;
    assign decouple       = r_decouple;
    assign rm_reset       = r_rm_reset;
    assign busy           = r_busy;
    assign error          = r_error;
    assign reconfig_count = r_count;

endmodule

// File: tb/tb_pr_decouple_seq.sv
// Bench for pr_decouple_seq: phase/elapsed-time model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pr_decouple_seq;

    localparam int DRN  = 4;
    localparam int RSTC = 16;
    localparam int SETC = 8;
    localparam int TO   = 50;

    localparam logic [2:0] P_RST = 3'd0, P_SET = 3'd1, P_IDLE = 3'd2,
                           P_DRN = 3'd3, P_GNT = 3'd4, P_ERR = 3'd5;
    localparam int W_ACK = 0, W_IDLE = 1, W_ERR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rm_data_in = '0;
    logic        pr_req = 1'b0, pr_done = 1'b0, err_clr = 1'b0;
    logic [15:0] data_out;
    logic        pr_ack, decouple, rm_reset, busy, error;
    logic [7:0]  reconfig_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pr_decouple_seq #(
        .DATA_W         (16),
        .DRAIN_CYCLES   (DRN),
        .RST_CYCLES     (RSTC),
        .SETTLE_CYCLES  (SETC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rm_data_in     (rm_data_in),
        .data_out       (data_out),
        .pr_req         (pr_req),
        .pr_ack         (pr_ack),
        .pr_done        (pr_done),
        .err_clr        (err_clr),
        .decouple       (decouple),
        .rm_reset       (rm_reset),
        .busy           (busy),
        .error          (error),
        .reconfig_count (reconfig_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: which phase we are in and how many cycles have elapsed in it.
    typedef struct packed {
        logic [2:0]  ph;
        logic [31:0] el;
        logic [7:0]  cnt;
        logic        ok;
        logic [15:0] data;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t cur, input logic req, input logic done,
                                    input logic clr, input logic [15:0] din);
        model_t n;
        n    = cur;
        if (cur.ph == P_IDLE) n.data = din;
        n.el = cur.el + 1;
        case (cur.ph)
            P_RST:  if (n.el == RSTC) begin n.ph = P_SET; n.el = 0; end
            P_SET:  if (n.el == SETC) begin
                        n.ph = P_IDLE; n.el = 0;
                        if (cur.ok) n.cnt = cur.cnt + 8'd1;
                        n.ok = 1'b0;
                    end
            P_IDLE: if (req) begin n.ph = P_DRN; n.el = 0; end
            P_DRN:  if (n.el == DRN) begin n.ph = P_GNT; n.el = 0; end
            P_GNT:  if (done) begin n.ph = P_RST; n.el = 0; n.ok = 1'b1; end
                    else if (n.el == TO) begin n.ph = P_ERR; n.el = 0; end
            P_ERR:  if (clr) begin n.ph = P_RST; n.el = 0; end
            default: n.ph = P_RST;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= step(m, pr_req, pr_done, err_clr, rm_data_in);
    end

    always @(negedge clk) begin
        chk("m_decouple", decouple,       m.ph != P_IDLE);
        chk("m_busy",     busy,           m.ph != P_IDLE);
        chk("m_pr_ack",   pr_ack,         m.ph == P_GNT);
        chk("m_rm_reset", rm_reset,       (m.ph == P_RST) || (m.ph == P_ERR));
        chk("m_error",    error,          m.ph == P_ERR);
        chk("m_data_out", data_out,       m.data);
        chk("m_count",    reconfig_count, m.cnt);
    end

    function automatic logic sig(input int w);
        case (w)
            W_ACK:   return pr_ack;
            W_IDLE:  return !busy;
            default: return error;
        endcase
    endfunction

    task automatic wait_for(input int w, input int maxc, output int c);
        c = 0;
        while (!sig(w) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (!sig(w)) chk($sformatf("wait_bound_%0d", w), sig(w), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Power-up
        repeat (3) @(negedge clk);
        chk("rst_decouple", decouple, 1);
        chk("rst_rm_reset", rm_reset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_pr_ack", pr_ack, 0);
        chk("rst_error", error, 0);
        chk("rst_data", data_out, 16'h0000);
        chk("rst_count", reconfig_count, 8'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("pwr_rm_reset_15", rm_reset, 1);
        @(negedge clk);
        chk("pwr_rm_reset_16", rm_reset, 0);
        chk("pwr_decouple_16", decouple, 1);
        repeat (8) @(negedge clk);
        chk("pwr_decouple_24", decouple, 0);
        chk("pwr_busy", busy, 0);
        chk("pwr_count", reconfig_count, 8'd0);

        // Nominal reconfiguration
        rm_data_in = 16'hA5A5;
        @(negedge clk);
        pr_req = 1'b1;
        @(negedge clk);
        pr_req = 1'b0;
        rm_data_in = 16'h1234;
        chk("nom_decouple", decouple, 1);
        wait_for(W_ACK, 20, c);
        chk("nom_ack_delay", c, DRN);
        chk("nom_frozen_a", data_out, 16'hA5A5);
        repeat (30) @(negedge clk);
        pr_done = 1'b1;
        @(negedge clk);
        pr_done = 1'b0;
        chk("nom_ack_drop", pr_ack, 0);
        chk("nom_rm_reset", rm_reset, 1);
        wait_for(W_IDLE, 40, c);
        chk("nom_recouple_delay", c, RSTC + SETC);
        chk("nom_frozen_b", data_out, 16'hA5A5);
        @(negedge clk);
        chk("nom_live", data_out, 16'h1234);
        chk("nom_count", reconfig_count, 8'd1);

        // Timeout, then recovery through ERROR
        pr_req = 1'b1;
        @(negedge clk);
        pr_req = 1'b0;
        wait_for(W_ACK, 20, c);
        wait_for(W_ERR, 100, c);
        chk("to_delay", c, TO);
        chk("to_rm_reset", rm_reset, 1);
        chk("to_ack", pr_ack, 0);
        pr_done = 1'b1;
        pr_req  = 1'b1;
        repeat (3) @(negedge clk);
        pr_done = 1'b0;
        pr_req  = 1'b0;
        chk("to_err_held", error, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err_clr", error, 0);
        chk("to_clr_rm_reset", rm_reset, 1);
        wait_for(W_IDLE, 40, c);
        chk("to_recover_delay", c, RSTC + SETC);
        chk("to_count", reconfig_count, 8'd1);

        // pr_done on the timeout cycle wins; pr_req in SETTLE is ignored
        pr_req = 1'b1;
        @(negedge clk);
        pr_req = 1'b0;
        wait_for(W_ACK, 20, c);
        repeat (TO - 1) @(negedge clk);
        pr_done = 1'b1;
        @(negedge clk);
        pr_done = 1'b0;
        chk("cf_no_error", error, 0);
        chk("cf_rm_reset", rm_reset, 1);
        repeat (17) @(negedge clk);
        pr_req = 1'b1;
        repeat (5) @(negedge clk);
        pr_req = 1'b0;
        wait_for(W_IDLE, 10, c);
        chk("cf_settle_len", c, 2);
        chk("cf_count", reconfig_count, 8'd2);
        repeat (3) @(negedge clk);
        chk("cf_req_ignored", busy, 0);

        // pr_done / err_clr in IDLE
        pr_done = 1'b1;
        err_clr = 1'b1;
        repeat (3) @(negedge clk);
        pr_done = 1'b0;
        err_clr = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_ack", pr_ack, 0);
        chk("idle_done_rm_reset", rm_reset, 0);

        // Wrap: 254 more successful reconfigurations reach 256
        for (int i = 0; i < 254; i++) begin
            rm_data_in = 16'(i * 37 + 5);
            pr_req = 1'b1;
            @(negedge clk);
            pr_req = 1'b0;
            wait_for(W_ACK, 20, c);
            repeat (i % 8) @(negedge clk);
            pr_done = 1'b1;
            @(negedge clk);
            pr_done = 1'b0;
            wait_for(W_IDLE, 40, c);
            if (i == 252) chk("wrap_255", reconfig_count, 8'd255);
        end
        @(negedge clk);
        chk("wrap_0", reconfig_count, 8'd0);

        // Reset asserted in GRANT
        pr_req = 1'b1;
        @(negedge clk);
        pr_req = 1'b0;
        wait_for(W_ACK, 20, c);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ack", pr_ack, 0);
        chk("mid_rst_rm_reset", rm_reset, 1);
        chk("mid_rst_decouple", decouple, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("mid_rst_rm_reset_15", rm_reset, 1);
        @(negedge clk);
        chk("mid_rst_rm_reset_16", rm_reset, 0);
        wait_for(W_IDLE, 20, c);
        chk("mid_rst_settle", c, SETC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
